// File: rtl/dsd_slave_rx.sv
// dsd_slave_rx
//   DSD / DoP bit-stream receiver. Two serial channels (ch1/ch2) arrive
//   LSB-first, 32 bits per channel per frame, sampled on the rising edge of
//   the DSD bit clock. Each completed frame is parked in a hold register and
//   replayed during the following frame as a stream of 16-bit words:
//     DSD (mode 0): 4 words, one every 8 bit clocks.
//     DoP (mode 1): 8 words, one every 4 bit clocks, each carrying one data
//                   byte plus a marker byte that alternates per frame.
//
// Ports
//   sck_in      DSD bit clock (only clock, rising edge)
//   rst         synchronous reset, active high
//   start_n     active-low start request, honoured only in IDLE
//   stop_n      active-low stop request, honoured only at a frame boundary
//   dop         packing select, latched at start (1 = DoP, 0 = DSD)
//   ch1_in      channel 1 serial data
//   ch2_in      channel 2 serial data
//   data_out    output word (zero when data_valid is low)
//   data_valid  data_out is valid this cycle
//   data_ready  consumer accepts data_out (no backpressure: a refused word is lost)
//   overrun     sticky flag, a word was dropped since the last start
//   busy        receiver is not idle
//
// state | meaning
// IDLE  | waiting for start_n; nothing emitted
// RECV  | shifting in frames, replaying the previous frame from hold
// DRAIN | inputs ignored, finishing replay of the last held frame

module dsd_slave_rx #(
  parameter logic [7:0] DOP_MARKER_A = 8'h05,
  parameter logic [7:0] DOP_MARKER_B = 8'hFA
) (
  input  logic        sck_in,
  input  logic        rst,
  input  logic        start_n,
  input  logic        stop_n,
  input  logic        dop,
  input  logic        ch1_in,
  input  logic        ch2_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sr1_q, sr1_d;
  logic [31:0] sr2_q, sr2_d;
  logic [31:0] hold1_q, hold1_d;
  logic [31:0] hold2_q, hold2_d;
  logic        hold_valid_q, hold_valid_d;
  logic        parity_q, parity_d;
  logic        mode_q, mode_d;
  logic        overrun_q, overrun_d;

  // FSM decode outputs
  logic        frame_end;
  logic        start_go;
  logic        cnt_en;
  logic        shift_en;
  logic        capture;
  logic        drain_done;

  // emission
  logic        slot;
  logic [1:0]  dsd_k;
  logic [2:0]  dop_k;
  logic [31:0] dop_src;
  logic [7:0]  dop_byte;
  logic [7:0]  marker;
  logic [15:0] word;

  assign frame_end = (bit_cnt_q == 5'd31);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sck_in) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!start_n)              state_d = ST_RECV;
      ST_RECV:  if (frame_end && !stop_n)  state_d = ST_DRAIN;
      ST_DRAIN: if (frame_end)             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    start_go   = 1'b0;
    cnt_en     = 1'b0;
    shift_en   = 1'b0;
    capture    = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // the start edge already captures bit 0 of frame 0
        start_go = !start_n;
        cnt_en   = !start_n;
        shift_en = !start_n;
      end
      ST_RECV: begin
        busy     = 1'b1;
        cnt_en   = 1'b1;
        shift_en = 1'b1;
        capture  = frame_end;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        cnt_en     = 1'b1;
        drain_done = frame_end;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    sr1_d        = sr1_q;
    sr2_d        = sr2_q;
    hold1_d      = hold1_q;
    hold2_d      = hold2_q;
    hold_valid_d = hold_valid_q;
    parity_d     = parity_q;
    mode_d       = mode_q;
    overrun_d    = overrun_q;

    if (cnt_en) bit_cnt_d = bit_cnt_q + 5'd1;

    if (shift_en) begin
      sr1_d = {ch1_in, sr1_q[31:1]};
      sr2_d = {ch2_in, sr2_q[31:1]};
    end

    if (start_go) begin
      mode_d   = dop;
      parity_d = 1'b0;
    end

    if (capture) begin
      // include the bit arriving on this very edge
      hold1_d      = {ch1_in, sr1_q[31:1]};
      hold2_d      = {ch2_in, sr2_q[31:1]};
      hold_valid_d = 1'b1;
      // parity only advances when an already-held frame is replaced,
      // so the first frame of a run always uses marker A
      if (hold_valid_q) parity_d = ~parity_q;
    end

    if (drain_done) hold_valid_d = 1'b0;

    if (start_go)
      overrun_d = 1'b0;
    else if (data_valid && !data_ready)
      overrun_d = 1'b1;
  end

  always_ff @(posedge sck_in) begin
    if (rst) begin
      bit_cnt_q    <= 5'd0;
      sr1_q        <= 32'd0;
      sr2_q        <= 32'd0;
      hold1_q      <= 32'd0;
      hold2_q      <= 32'd0;
      hold_valid_q <= 1'b0;
      parity_q     <= 1'b0;
      mode_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      sr1_q        <= sr1_d;
      sr2_q        <= sr2_d;
      hold1_q      <= hold1_d;
      hold2_q      <= hold2_d;
      hold_valid_q <= hold_valid_d;
      parity_q     <= parity_d;
      mode_q       <= mode_d;
      overrun_q    <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word emission, decoded straight from registered state (no added latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    dsd_k    = bit_cnt_q[4:3];
    dop_k    = bit_cnt_q[4:2];
    slot     = mode_q ? (bit_cnt_q[1:0] == 2'd0) : (bit_cnt_q[2:0] == 3'd0);
    dop_src  = dop_k[2] ? hold2_q : hold1_q;
    dop_byte = dop_src[{dop_k[1:0], 3'b000} +: 8];
    marker   = parity_q ? DOP_MARKER_B : DOP_MARKER_A;
    word     = 16'h0000;
    if (mode_q) begin
      // marker swaps halves on alternate slots
      word = dop_k[0] ? {marker, dop_byte} : {dop_byte, marker};
    end else begin
      case (dsd_k)
        2'd0:    word = hold1_q[15:0];
        2'd1:    word = hold1_q[31:16];
        2'd2:    word = hold2_q[15:0];
        default: word = hold2_q[31:16];
      endcase
    end
  end

  assign data_valid = hold_valid_q && slot;
  assign data_out   = data_valid ? word : 16'h0000;
  assign overrun    = overrun_q;

endmodule

// File: doc/dsd_slave_rx.md
Name: dsd_slave_rx

Overview:
- DSD/DoP bit-stream receiver; the counterpart of the team's DSD master transmitter.
- Samples two serial DSD channels (ch1/ch2, LSB-first, 32 bits per channel per frame) on the rising edge of the incoming bit clock.
- Deserialises each frame and re-emits it as a stream of 16-bit words with a valid/ready strobe toward the capture FIFO.
- Used for loopback test and for the record path.

Parameters:
DOP_MARKER_A, 8'h05, DoP marker byte used on even frames.
DOP_MARKER_B, 8'hFA, DoP marker byte used on odd frames.

Ports:
sck_in  input  1  DSD bit clock; the only clock; all logic on posedge (transmitter launches on negedge)
rst  input  1  synchronous reset, active-high
start_n  input  1  active-low start request, sampled in IDLE
stop_n  input  1  active-low stop request, sampled at frame boundary
dop  input  1  1 = DoP word packing, 0 = plain DSD packing; latched at start
ch1_in  input  1  channel 1 serial data
ch2_in  input  1  channel 2 serial data
data_out  output  16  output word
data_valid  output  1  data_out valid this cycle
data_ready  input  1  consumer accepts data_out
overrun  output  1  sticky: a word was dropped
busy  output  1  state != IDLE

Behaviour:
- Reset values: state IDLE, bit_cnt 0, shift regs 0, hold regs 0, hold_valid 0, frame parity 0, mode 0, overrun 0. Outputs: data_out 16'h0000, data_valid 0, busy 0.
- States: IDLE, RECV, DRAIN.
- IDLE:
  - start_n low → RECV.
  - On the same edge: latch mode <= dop, clear overrun, clear frame parity.
  - The ch1_in/ch2_in sampled on that edge are bit 0 of frame 0.
- RECV, every edge:
  - sr1 <= {ch1_in, sr1[31:1]}; sr2 likewise (LSB-first).
  - bit_cnt <= bit_cnt + 1; 5-bit, wraps 31→0.
- Frame boundary = the edge capturing bit 31 (bit_cnt == 31):
  - hold1/hold2 <= completed shifted words (including this bit).
  - hold_valid <= 1.
  - Frame parity toggles when a previously held frame is replaced; first frame uses parity 0.
- stop_n low at a frame boundary → DRAIN. stop_n at any other edge is ignored; the source must hold it until the boundary.
- DRAIN:
  - Serial inputs ignored; bit_cnt keeps counting.
  - At bit_cnt == 31: hold_valid <= 0, state → IDLE.
  - Requires sck_in to keep running for 32 edges after stop.
- Emission: data_valid = hold_valid and slot(bit_cnt); registered-state decode, no extra latency.
- DSD mode (mode = 0):
  - Slots at bit_cnt[2:0] == 0; index k = bit_cnt[4:3].
  - k = 0..3 → hold1[15:0], hold1[31:16], hold2[15:0], hold2[31:16].
- DoP mode (mode = 1):
  - Slots at bit_cnt[1:0] == 0; index k = bit_cnt[4:2].
  - byte_k = byte (k mod 4) of hold1 for k < 4, of hold2 for k ≥ 4.
  - marker = DOP_MARKER_A if parity 0, else DOP_MARKER_B.
  - Even k → {byte_k, marker}; odd k → {marker, byte_k}.
- Latency: word 0 of frame N is valid in the cycle immediately after the edge capturing bit 31 of frame N. The last word appears 24 (DSD) or 28 (DoP) cycles later.
- Frame overlap: hold is replaced at the next boundary, after all slots have been emitted; no double buffer needed beyond hold.
- No backpressure. If data_valid and !data_ready, the word is dropped and overrun <= 1. overrun is sticky until rst or the next start.
- data_out = 0 when data_valid is low.
- dop changes while busy are ignored.
- rst asserted mid-frame: next edge returns everything to reset values; the partial frame is discarded and no word is emitted.
- start_n low while in RECV/DRAIN is ignored.

Test Plan:
- DSD loopback: start with dop = 0; ch1 carries 0x12345678 and ch2 carries 0x9ABCDEF0, LSB-first; data_ready = 1 → words 0x5678, 0x1234, 0xDEF0, 0x9ABC at bit_cnt 0/8/16/24 of the next frame; overrun = 0.
- DoP packing: same streams with dop = 1 → 0x7805, 0x0556, 0x3405, 0x0512, 0xF005, 0x05DE, 0xBC05, 0x059A. The second frame uses marker 0xFA (e.g. first word 0xxxFA); the third frame uses 0x05 again.
- Stop/drain:
  - stop_n pulsed low mid-frame 2 and released → no effect.
  - stop_n held low through the frame-2 boundary → all frame-2 words emitted, then busy = 0 exactly 32 edges after the boundary; no frame-3 words.
- Overrun: data_ready = 0 during slot 2 of a DSD frame → that word not accepted, overrun = 1 and it stays 1 across later frames; a new start clears it.
- Reset mid-operation: rst = 1 at bit 17 of frame 1 → next cycle busy = 0, data_valid = 0, data_out = 0. A fresh start afterwards yields correct frame 0 words.
- Mode latch: dop toggled at bit 5 of frame 0 after a DSD start → output remains 4-word DSD packing for all frames.
